// File: rtl/jtdsp16_pkg.sv
// Shared constants for the DSP16 serial-output receiver (QSound sound DAC side).
package jtdsp16_pkg;

    typedef enum logic {
        SDAC_IDLE  = 1'b0,
        SDAC_SHIFT = 1'b1
    } sdac_state_t;

    localparam int SDAC_WIDTH = 16;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/jtdsp16_sdac_if.sv
// Serial link from the DSP16 SIO plus the stereo sample outputs towards the mixer.
interface jtdsp16_sdac_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic             ock;
    logic             sdo;
    logic             old;
    logic             doen;
    logic [WIDTH-1:0] word;
    logic             word_vld;
    logic             word_ch;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             pair_vld;
    logic             short_err;
    logic             busy;

    modport slave (
        input  en, ock, sdo, old,
        output doen, word, word_vld, word_ch, left, right, pair_vld, short_err, busy
    );

    modport master (
        output en, ock, sdo, old,
        input  doen, word, word_vld, word_ch, left, right, pair_vld, short_err, busy
    );

endinterface

// File: rtl/jtdsp16_sdac_shift.sv
// Deserialiser: shift register, bit counter and LSB/MSB-first bit placement.
module jtdsp16_sdac_shift
    import jtdsp16_pkg::*;
#(
    parameter int WIDTH     = SDAC_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             rise,
    input  logic             start,
    input  logic             din,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] sreg;

    // dout is the shift register with the incoming bit already merged, so the
    // completed word can be loaded on the same edge that captures its last bit.
    always_comb begin
        pos  = start ? '0 : cnt;
        dout = start ? '0 : sreg;
        if (MSB_FIRST) begin
            dout[CW'(WIDTH-1) - pos] = din;
        end else begin
            dout[pos] = din;
        end
        done    = rise & ~start & (cnt == CW'(WIDTH-1));
        cnt_nxt = done ? '0 : pos + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (clr) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (rise) begin
            cnt  <= cnt_nxt;
            sreg <= dout;
        end
    end

endmodule

// File: rtl/jtdsp16_sdac.sv
// DSP16 serial output receiver: frames words on old, tags left/right, holds stereo pair.
module jtdsp16_sdac
    import jtdsp16_pkg::*;
#(
    parameter int WIDTH     = SDAC_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    jtdsp16_sdac_if.slave      bus
);

    sdac_state_t      state;
    sdac_state_t      state_nxt;
    logic             doen;
    logic             ock_l;
    logic             rise;
    logic             smp;
    logic             ch;
    logic             ch_nxt;
    logic             sh_rise;
    logic             sh_done;
    logic [WIDTH-1:0] sh_dout;
    logic             vld_nxt;
    logic             pair_nxt;
    logic             short_nxt;
    logic [WIDTH-1:0] word;
    logic             word_vld;
    logic             word_ch;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             pair_vld;
    logic             short_err;

    assign rise = bus.ock & ~ock_l;
    assign smp  = rise & doen;
    // In IDLE only an old-framed rise reaches the shifter; stray clocks are dropped.
    assign sh_rise = smp & ((state == SDAC_SHIFT) | bus.old);

    jtdsp16_sdac_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (~doen),
        .rise  (sh_rise),
        .start (bus.old),
        .din   (bus.sdo),
        .done  (sh_done),
        .dout  (sh_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SDAC_IDLE;
            ch    <= CH_LEFT;
            doen  <= 1'b0;
            ock_l <= 1'b0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
            doen  <= bus.en;
            ock_l <= bus.ock;
        end
    end

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        short_nxt = 1'b0;
        vld_nxt   = sh_done;
        pair_nxt  = sh_done & (ch == CH_RIGHT);
        if (!doen) begin
            // Receiver disabled: drop any partial word and resync on the left channel.
            state_nxt = SDAC_IDLE;
            ch_nxt    = CH_LEFT;
        end else begin
            case (state)
                SDAC_IDLE: begin
                    if (smp && bus.old) state_nxt = SDAC_SHIFT;
                end
                SDAC_SHIFT: begin
                    if (smp && bus.old) begin
                        short_nxt = 1'b1;
                    end else if (sh_done) begin
                        state_nxt = SDAC_IDLE;
                        ch_nxt    = ~ch;
                    end
                end
                default: state_nxt = SDAC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word      <= '0;
            word_vld  <= 1'b0;
            word_ch   <= CH_LEFT;
            left      <= '0;
            right     <= '0;
            pair_vld  <= 1'b0;
            short_err <= 1'b0;
        end else begin
            word_vld  <= vld_nxt;
            pair_vld  <= pair_nxt;
            short_err <= short_nxt;
            if (sh_done) begin
                word    <= sh_dout;
                word_ch <= ch;
                if (ch == CH_RIGHT) begin
                    right <= sh_dout;
                end else begin
                    left <= sh_dout;
                end
            end
        end
    end

    assign bus.doen      = doen;
    assign bus.word      = word;
    assign bus.word_vld  = word_vld;
    assign bus.word_ch   = word_ch;
    assign bus.left      = left;
    assign bus.right     = right;
    assign bus.pair_vld  = pair_vld;
    assign bus.short_err = short_err;
    assign bus.busy      = (state == SDAC_SHIFT);

endmodule

// File: tb/tb_jtdsp16_sdac.sv
// Scoreboard bench for jtdsp16_sdac: 16-bit LSB-first and 8-bit MSB-first instances.
module tb_jtdsp16_sdac;
    import jtdsp16_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jtdsp16_sdac_if #(.WIDTH(16)) b0 ();
    jtdsp16_sdac_if #(.WIDTH(8))  b1 ();

    jtdsp16_sdac #(.WIDTH(16), .MSB_FIRST(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    jtdsp16_sdac #(.WIDTH(8),  .MSB_FIRST(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef struct {
        logic [15:0] w;
        logic        ch;
        logic        pair;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   vld_cnt0 = 0, pair_cnt0 = 0, short_cnt0 = 0, busy_cnt0 = 0;
    int   vld_cnt1 = 0, short_cnt1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a word.
    always @(negedge clk) begin : mon
        exp_t e;
        if (b0.word_vld) begin
            vld_cnt0++;
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_word: got 0x%0h, expected no word", b0.word);
            end else begin
                e = q0.pop_front();
                chk("dut0_word", b0.word, e.w);
                chk("dut0_word_ch", b0.word_ch, e.ch);
                chk("dut0_pair_vld", b0.pair_vld, e.pair);
                if (e.ch == CH_RIGHT) chk("dut0_right_held", b0.right, e.w);
                else                  chk("dut0_left_held", b0.left, e.w);
            end
        end
        if (b0.pair_vld) begin
            pair_cnt0++;
            chk("dut0_pair_with_vld", b0.word_vld, 1);
        end
        if (b0.short_err) begin
            short_cnt0++;
            chk("dut0_short_excl_vld", b0.word_vld, 0);
        end
        if (b0.busy) busy_cnt0++;

        if (b1.word_vld) begin
            vld_cnt1++;
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_word: got 0x%0h, expected no word", b1.word);
            end else begin
                e = q1.pop_front();
                chk("dut1_word", b1.word, e.w);
                chk("dut1_word_ch", b1.word_ch, e.ch);
                chk("dut1_pair_vld", b1.pair_vld, e.pair);
            end
        end
        if (b1.short_err) short_cnt1++;
    end

    task automatic clk_bit0(input logic d, input logic o);
        b0.ock = 1'b0;
        b0.sdo = d;
        b0.old = o;
        repeat (4) @(negedge clk);
        b0.ock = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send0(input logic [15:0] w, input int unsigned nbits);
        for (int unsigned i = 0; i < nbits; i++) clk_bit0(w[i], i == 0);
        b0.old = 1'b0;
    endtask

    task automatic push0(input logic [15:0] w, input logic ch, input logic pair);
        exp_t e;
        e.w = w;
        e.ch = ch;
        e.pair = pair;
        q0.push_back(e);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin : stim
        logic [0:7] seq;
        int         v_snap, b_snap, s_snap;
        exp_t       e1;

        b0.en = 1'b0; b0.ock = 1'b0; b0.sdo = 1'b0; b0.old = 1'b0;
        b1.en = 1'b0; b1.ock = 1'b0; b1.sdo = 1'b0; b1.old = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs0", {b0.doen, b0.word, b0.word_vld, b0.word_ch, b0.left,
                               b0.pair_vld, b0.short_err, b0.busy}, 0);
        chk("reset_right0", b0.right, 0);
        rst_n = 1'b1;
        b0.en = 1'b1;
        b1.en = 1'b1;
        repeat (2) @(negedge clk);
        chk("doen_after_reset", b0.doen, 1);

        // LSB-first stereo frame
        push0(16'h1234, CH_LEFT, 1'b0);
        push0(16'hABCD, CH_RIGHT, 1'b1);
        send0(16'h1234, 16);
        send0(16'hABCD, 16);
        repeat (4) @(negedge clk);
        chk("t1_left", b0.left, 16'h1234);
        chk("t1_right", b0.right, 16'hABCD);
        chk("t1_word_count", vld_cnt0, 2);
        chk("t1_pair_count", pair_cnt0, 1);

        // 8-bit MSB-first with latency check on the final bit
        seq = 8'b1011_0001;
        e1.w = 16'h00B1; e1.ch = CH_LEFT; e1.pair = 1'b0;
        q1.push_back(e1);
        for (int i = 0; i < 8; i++) begin
            b1.ock = 1'b0;
            b1.sdo = seq[i];
            b1.old = (i == 0);
            repeat (4) @(negedge clk);
            b1.ock = 1'b1;
            if (i == 7) begin
                chk("t2_vld_before_edge", b1.word_vld, 0);
                @(posedge clk); #1;
                chk("t2_vld_one_clk", b1.word_vld, 1);
                chk("t2_word", b1.word, 8'hB1);
                @(posedge clk); #1;
                chk("t2_vld_pulse_end", b1.word_vld, 0);
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        b1.old = 1'b0;

        // Short frame: 9 bits then a full left word
        send0(16'h0FFF, 9);
        push0(16'h00FF, CH_LEFT, 1'b0);
        send0(16'h00FF, 16);
        repeat (4) @(negedge clk);
        chk("t3_short_count", short_cnt0, 1);
        chk("t3_pair_count", pair_cnt0, 1);

        // en drop in the middle of a right word
        send0(16'hFFFF, 5);
        chk("t4_busy_partial", b0.busy, 1);
        b0.en = 1'b0;
        chk("t4_doen_still_high", b0.doen, 1);
        @(posedge clk); #1;
        chk("t4_doen_low", b0.doen, 0);
        repeat (2) @(negedge clk);
        chk("t4_busy_cleared", b0.busy, 0);
        b0.en = 1'b1;
        chk("t4_doen_still_low", b0.doen, 0);
        @(posedge clk); #1;
        chk("t4_doen_high", b0.doen, 1);
        @(negedge clk);
        push0(16'h5555, CH_LEFT, 1'b0);
        push0(16'hAAAA, CH_RIGHT, 1'b1);
        send0(16'h5555, 16);
        send0(16'hAAAA, 16);
        repeat (4) @(negedge clk);
        chk("t4_pair_count", pair_cnt0, 2);
        chk("t4_short_count", short_cnt0, 1);

        // Async reset mid-word with ock held high
        send0(16'hFFFF, 3);
        b0.old = 1'b1;
        b0.sdo = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("t5_reset_outputs0", {b0.doen, b0.word, b0.word_vld, b0.word_ch, b0.left,
                                  b0.pair_vld, b0.short_err, b0.busy}, 0);
        chk("t5_reset_right0", b0.right, 0);
        chk("t5_reset_word1", b1.word, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("t5_no_spurious_busy", b0.busy, 0);
        b0.old = 1'b0;
        push0(16'h0001, CH_LEFT, 1'b0);
        send0(16'h0001, 16);
        repeat (4) @(negedge clk);
        chk("t5_left", b0.left, 16'h0001);
        chk("t5_right_cleared", b0.right, 0);
        chk("t5_short_count", short_cnt0, 1);

        // Stray clocks in IDLE
        v_snap = vld_cnt0;
        b_snap = busy_cnt0;
        s_snap = short_cnt0;
        for (int i = 0; i < 20; i++) clk_bit0(i[0], 1'b0);
        repeat (4) @(negedge clk);
        chk("t6_no_word", vld_cnt0 - v_snap, 0);
        chk("t6_no_busy", busy_cnt0 - b_snap, 0);
        chk("t6_no_short", short_cnt0 - s_snap, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("dut1_word_count", vld_cnt1, 1);
        chk("dut1_short_count", short_cnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
